// File: rtl/sys_cmd_host_if.sv
// rtl/sys_cmd_host_if.sv - command request, TX byte stream and RX byte stream bundle for sys_cmd_host
//
// Signals:
//   CMD_VLD/CMD_RDY   command request handshake
//   CMD_TYPE          0=RF write, 1=RF read, 2=ALU with operands, 3=ALU without operands
//   CMD_ADDR/WDATA    register-file address and write data
//   CMD_OPA/OPB/FUN   ALU operands and function code
//   TX_DATA/VLD/RDY   outgoing frame bytes, valid/ready handshake
//   RX_DATA/VLD       incoming response bytes, one-cycle valid pulse per byte
//   RSP_DATA/RSP_VLD  assembled response and its one-cycle valid pulse
//   CMD_DONE/TIMEOUT  completion pulse and timeout flag
// Modports: slave (the host block), master (whoever drives commands and bytes).
interface sys_cmd_host_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                    CMD_VLD;
    logic [1:0]              CMD_TYPE;
    logic [ADDR_WIDTH-1:0]   CMD_ADDR;
    logic [DATA_WIDTH-1:0]   CMD_WDATA;
    logic [DATA_WIDTH-1:0]   CMD_OPA;
    logic [DATA_WIDTH-1:0]   CMD_OPB;
    logic [3:0]              CMD_FUN;
    logic                    CMD_RDY;
    logic [DATA_WIDTH-1:0]   TX_DATA;
    logic                    TX_VLD;
    logic                    TX_RDY;
    logic [DATA_WIDTH-1:0]   RX_DATA;
    logic                    RX_VLD;
    logic [2*DATA_WIDTH-1:0] RSP_DATA;
    logic                    RSP_VLD;
    logic                    CMD_DONE;
    logic                    TIMEOUT;

    modport slave (
        input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_WDATA, CMD_OPA, CMD_OPB, CMD_FUN,
        input  TX_RDY, RX_DATA, RX_VLD,
        output CMD_RDY, TX_DATA, TX_VLD, RSP_DATA, RSP_VLD, CMD_DONE, TIMEOUT
    );

    modport master (
        output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_WDATA, CMD_OPA, CMD_OPB, CMD_FUN,
        output TX_RDY, RX_DATA, RX_VLD,
        input  CMD_RDY, TX_DATA, TX_VLD, RSP_DATA, RSP_VLD, CMD_DONE, TIMEOUT
    );
endinterface

// File: rtl/sys_cmd_host.sv
// rtl/sys_cmd_host.sv - host-side command initiator: serializes a command frame, collects the response
//
// Ports:
//   CLK  clock
//   RST  asynchronous reset, active-high
//   bus  sys_cmd_host_if.slave: command request, TX byte stream, RX byte stream,
//        assembled response and completion/timeout pulses
module sys_cmd_host #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                CLK,
    input  logic                RST,
    sys_cmd_host_if.slave       bus
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CMD_WR     = 2'd0;
    localparam logic [1:0] CMD_RD     = 2'd1;
    localparam logic [1:0] CMD_ALU    = 2'd2;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              typ_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, opa_q, opb_q;
    logic [3:0]              fun_q;
    logic [1:0]              idx_q;
    logic                    rx_cnt_q;
    logic [TW-1:0]           tmr_q;
    logic                    to_q;
    logic [2*DATA_WIDTH-1:0] rsp_q;

    logic [1:0]              frame_last;
    logic                    rsp_final;
    logic [DATA_WIDTH-1:0]   tx_byte;

    // Index of the last frame byte for the latched command type.
    always_comb begin
        case (typ_q)
            CMD_WR:  frame_last = 2'd2;
            CMD_ALU: frame_last = 2'd3;
            default: frame_last = 2'd1;
        endcase
    end

    // A read expects one response byte, both ALU forms expect two.
    assign rsp_final = (typ_q == CMD_RD) || rx_cnt_q;

    always_comb begin
        tx_byte = '0;
        case (typ_q)
            CMD_WR: begin
                case (idx_q)
                    2'd0:    tx_byte = DATA_WIDTH'(8'hAA);
                    2'd1:    tx_byte = DATA_WIDTH'(addr_q);
                    default: tx_byte = wdata_q;
                endcase
            end
            CMD_RD: begin
                if (idx_q == 2'd0) tx_byte = DATA_WIDTH'(8'hBB);
                else               tx_byte = DATA_WIDTH'(addr_q);
            end
            CMD_ALU: begin
                case (idx_q)
                    2'd0:    tx_byte = DATA_WIDTH'(8'hCC);
                    2'd1:    tx_byte = opa_q;
                    2'd2:    tx_byte = opb_q;
                    default: tx_byte = DATA_WIDTH'(fun_q);
                endcase
            end
            default: begin
                if (idx_q == 2'd0) tx_byte = DATA_WIDTH'(8'hDD);
                else               tx_byte = DATA_WIDTH'(fun_q);
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.CMD_VLD) state_d = SEND;
            end
            SEND: begin
                if (bus.TX_RDY && (idx_q == frame_last))
                    state_d = (typ_q == CMD_WR) ? FINISH : WAIT_RSP;
            end
            WAIT_RSP: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (bus.RX_VLD) begin
                    if (rsp_final) state_d = FINISH;
                end else if (tmr_q == '0) begin
                    state_d = FINISH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            typ_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            fun_q    <= '0;
            idx_q    <= '0;
            rx_cnt_q <= 1'b0;
            tmr_q    <= '0;
            to_q     <= 1'b0;
            rsp_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.CMD_VLD) begin
                        typ_q    <= bus.CMD_TYPE;
                        addr_q   <= bus.CMD_ADDR;
                        wdata_q  <= bus.CMD_WDATA;
                        opa_q    <= bus.CMD_OPA;
                        opb_q    <= bus.CMD_OPB;
                        fun_q    <= bus.CMD_FUN;
                        idx_q    <= '0;
                        rx_cnt_q <= 1'b0;
                        to_q     <= 1'b0;
                        rsp_q    <= '0;
                    end
                end
                SEND: begin
                    if (bus.TX_RDY) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == frame_last) tmr_q <= TMR_LOAD;
                    end
                end
                WAIT_RSP: begin
                    if (bus.RX_VLD) begin
                        // Response is LSB first.
                        if (!rx_cnt_q) rsp_q[DATA_WIDTH-1:0]            <= bus.RX_DATA;
                        else           rsp_q[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.RX_DATA;
                        rx_cnt_q <= 1'b1;
                        tmr_q    <= TMR_LOAD;
                    end else if (tmr_q == '0) begin
                        to_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.CMD_RDY  = (state_q == IDLE);
    assign bus.TX_VLD   = (state_q == SEND);
    assign bus.TX_DATA  = (state_q == SEND) ? tx_byte : '0;
    assign bus.RSP_DATA = rsp_q;
    assign bus.CMD_DONE = (state_q == FINISH);
    assign bus.TIMEOUT  = (state_q == FINISH) && to_q;
    assign bus.RSP_VLD  = (state_q == FINISH) && !to_q && (typ_q != CMD_WR);
endmodule
